// File: rtl/dphy_rx_pkg.sv
// Shared types and constants for the 4-lane D-PHY RX deskew aligner.
package dphy_rx_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 16;

  typedef logic [LANE_W-1:0] lane_word_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    STREAM,
    DRAIN,
    ERR
  } rx_state_e;

endpackage

// File: rtl/dphy_rx_lane_fifo.sv
// Single-lane deskew FIFO; pointers carry an extra wrap bit to tell full from empty.
module dphy_rx_lane_fifo
  import dphy_rx_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         one_o,
  output logic         ovf_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d, used;
  logic         do_push, do_pop;

  assign used    = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign one_o   = (used == (AW+1)'(1));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees a slot, so a push to a full FIFO is only lost without one.
  assign do_push = push_i & (~full_o | do_pop);
  assign ovf_o   = push_i & full_o & ~do_pop;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dphy_rx_4lane_aligner.sv
// Deskews up to four D-PHY HS PPI lanes and emits one lane-aligned word per cycle.
module dphy_rx_4lane_aligner
  import dphy_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SKEW_DEPTH = 4
) (
  input  logic                  SLOWCLK,
  input  logic                  RESET_N,
  input  logic [1:0]            lane_cnt,
  input  logic                  RX_ACTIVE_HS_LAN0,
  input  logic                  RX_ACTIVE_HS_LAN1,
  input  logic                  RX_ACTIVE_HS_LAN2,
  input  logic                  RX_ACTIVE_HS_LAN3,
  input  logic                  RX_SYNC_HS_LAN0,
  input  logic                  RX_SYNC_HS_LAN1,
  input  logic                  RX_SYNC_HS_LAN2,
  input  logic                  RX_SYNC_HS_LAN3,
  input  logic                  RX_VALID_HS_LAN0,
  input  logic                  RX_VALID_HS_LAN1,
  input  logic                  RX_VALID_HS_LAN2,
  input  logic                  RX_VALID_HS_LAN3,
  input  logic [DATA_W-1:0]     RX_DATA_HS_LAN0,
  input  logic [DATA_W-1:0]     RX_DATA_HS_LAN1,
  input  logic [DATA_W-1:0]     RX_DATA_HS_LAN2,
  input  logic [DATA_W-1:0]     RX_DATA_HS_LAN3,
  output logic [4*DATA_W-1:0]   out_data,
  output logic                  out_valid,
  output logic [3:0]            out_mask,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  err_align,
  output logic                  err_ovf
);

  localparam int unsigned   CW    = $clog2(SKEW_DEPTH) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(SKEW_DEPTH - 1);

  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] arm_q, arm_d, en_q, en_d, en_now, en;
  logic       sop_pend_q, sop_pend_d;
  logic [4*DATA_W-1:0] out_data_q, out_data_d;
  logic       out_valid_q, out_sop_q, out_eop_q;
  logic [3:0] out_mask_q;

  logic [3:0] act, sync, vld, arm_now, push, pop, full, empty, one, ovf;
  logic [DATA_W-1:0] din [NUM_LANES];
  logic [DATA_W-1:0] dout [NUM_LANES];
  logic armed_all, all_ne, all_inact, fin, eop, flush, align_err;

  assign act  = {RX_ACTIVE_HS_LAN3, RX_ACTIVE_HS_LAN2, RX_ACTIVE_HS_LAN1, RX_ACTIVE_HS_LAN0};
  assign sync = {RX_SYNC_HS_LAN3, RX_SYNC_HS_LAN2, RX_SYNC_HS_LAN1, RX_SYNC_HS_LAN0};
  assign vld  = {RX_VALID_HS_LAN3, RX_VALID_HS_LAN2, RX_VALID_HS_LAN1, RX_VALID_HS_LAN0};
  assign din[0] = RX_DATA_HS_LAN0;
  assign din[1] = RX_DATA_HS_LAN1;
  assign din[2] = RX_DATA_HS_LAN2;
  assign din[3] = RX_DATA_HS_LAN3;

  always_comb begin
    en_now = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) en_now[k] = (2'(k) <= lane_cnt);
  end

  assign en        = (state_q == IDLE) ? en_now : en_q;
  assign arm_now   = ((state_q == IDLE) || (state_q == WAIT_SYNC)) ? (en & sync & vld) : '0;
  assign armed_all = &(~en | arm_q | arm_now);
  assign push      = en & vld & ((arm_q & act) | arm_now);
  assign all_ne    = &(~en | ~empty);
  assign all_inact = ~|(en & act);
  assign fin       = &(~en | empty | one);
  assign flush     = (state_q == ERR);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    dphy_rx_lane_fifo #(.W(DATA_W), .DEPTH(SKEW_DEPTH)) u_fifo (
      .clk_i   (SLOWCLK),
      .rst_ni  (RESET_N),
      .push_i  (push[k]),
      .pop_i   (pop[k]),
      .flush_i (flush),
      .data_i  (din[k]),
      .data_o  (dout[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .one_o   (one[k]),
      .ovf_o   (ovf[k])
    );
  end

  always_comb begin
    pop = '0;
    case (state_q)
      STREAM:  if (all_ne) pop = en;
      DRAIN:   pop = en & ~empty;
      default: pop = '0;
    endcase
  end

  assign eop = (|pop) & fin & ((state_q == DRAIN) | all_inact);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    align_err = 1'b0;
    case (state_q)
      // All lanes syncing together skip the wait so the first pop still lands one cycle later.
      IDLE: if (|arm_now) begin
        state_d = armed_all ? STREAM : WAIT_SYNC;
        cnt_d   = CW'(1);
      end
      WAIT_SYNC: begin
        cnt_d = cnt_q + CW'(1);
        if (armed_all) state_d = STREAM;
        else if (cnt_q >= LIMIT || |(en & full)) begin
          align_err = 1'b1;
          state_d   = ERR;
        end
      end
      STREAM: if (eop) state_d = IDLE;
              else if (all_inact) state_d = DRAIN;
      DRAIN:  if (eop || !(|pop)) state_d = IDLE;
      ERR:    if (all_inact) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (|ovf) state_d = ERR;
  end

  always_comb begin
    arm_d      = ((state_d == IDLE) || (state_d == ERR)) ? '0 : (arm_q | arm_now);
    en_d       = (state_q == IDLE) ? en_now : en_q;
    sop_pend_d = (state_q == IDLE) ? 1'b1 : ((|pop) ? 1'b0 : sop_pend_q);
    out_data_d = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++)
      if (pop[k]) out_data_d[k*DATA_W +: DATA_W] = dout[k];
  end

  always_ff @(posedge SLOWCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      arm_q       <= '0;
      en_q        <= '0;
      sop_pend_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      arm_q       <= arm_d;
      en_q        <= en_d;
      sop_pend_q  <= sop_pend_d;
      out_data_q  <= out_data_d;
      out_valid_q <= |pop;
      out_mask_q  <= pop;
      out_sop_q   <= (|pop) & sop_pend_q;
      out_eop_q   <= eop;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign err_align = align_err;
  assign err_ovf   = |ovf;

endmodule

// File: tb/tb_dphy_rx_4lane_aligner.sv
// Randomized bench for the 4-lane aligner against a list-based burst model.
module tb_dphy_rx_4lane_aligner;
  import dphy_rx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] lc = 2'd3;
  logic [3:0] act = '0, syn = '0, vld = '0;
  lane_word_t din [4] = '{default: '0};
  logic [63:0] out_data;
  logic out_valid, out_sop, out_eop, err_align, err_ovf;
  logic [3:0] out_mask;

  dphy_rx_4lane_aligner #(.DATA_W(16), .SKEW_DEPTH(4)) dut (
    .SLOWCLK(clk), .RESET_N(rst_n), .lane_cnt(lc),
    .RX_ACTIVE_HS_LAN0(act[0]), .RX_ACTIVE_HS_LAN1(act[1]),
    .RX_ACTIVE_HS_LAN2(act[2]), .RX_ACTIVE_HS_LAN3(act[3]),
    .RX_SYNC_HS_LAN0(syn[0]), .RX_SYNC_HS_LAN1(syn[1]),
    .RX_SYNC_HS_LAN2(syn[2]), .RX_SYNC_HS_LAN3(syn[3]),
    .RX_VALID_HS_LAN0(vld[0]), .RX_VALID_HS_LAN1(vld[1]),
    .RX_VALID_HS_LAN2(vld[2]), .RX_VALID_HS_LAN3(vld[3]),
    .RX_DATA_HS_LAN0(din[0]), .RX_DATA_HS_LAN1(din[1]),
    .RX_DATA_HS_LAN2(din[2]), .RX_DATA_HS_LAN3(din[3]),
    .out_data(out_data), .out_valid(out_valid), .out_mask(out_mask),
    .out_sop(out_sop), .out_eop(out_eop), .err_align(err_align), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] d;
    logic [3:0]  m;
    logic        sop;
    logic        eop;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  int n_align, n_ovf, align_cyc;
  int n_tests = 0, n_fail = 0;
  int sk [4], nk [4];
  lane_word_t wd [4][16];
  int base;
  logic [72:0] snap;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) obs_q.push_back('{cyc, out_data, out_mask, out_sop, out_eop});
      if (err_align) begin n_align++; align_cyc = cyc; end
      if (err_ovf) n_ovf++;
    end
  end

  task automatic set_burst(input int l, input int maxskew, input int n);
    lc = 2'(l);
    for (int k = 0; k < 4; k++) begin
      sk[k] = (k <= l) ? $urandom_range(0, maxskew) : 0;
      nk[k] = (k <= l) ? n : 0;
      for (int i = 0; i < 16; i++) wd[k][i] = lane_word_t'($urandom);
    end
  endtask

  // Drives one burst; lane k starts at relative cycle sk[k] and sends nk[k] back-to-back words.
  task automatic drive(input bit noise, input int rst_at);
    int last = 0;
    obs_q.delete();
    n_align = 0; n_ovf = 0; align_cyc = -1;
    for (int k = 0; k < 4; k++) if (sk[k] + nk[k] > last) last = sk[k] + nk[k];
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) base = cyc;
      for (int k = 0; k < 4; k++) begin
        if (k <= int'(lc)) begin
          act[k] = (c >= sk[k]) && (c < sk[k] + nk[k]);
          vld[k] = act[k];
          syn[k] = (c == sk[k]) && (nk[k] > 0);
          din[k] = act[k] ? wd[k][c - sk[k]] : lane_word_t'($urandom);
        end else if (noise) begin
          act[k] = 1'($urandom); vld[k] = 1'($urandom); syn[k] = 1'($urandom);
          din[k] = lane_word_t'($urandom);
        end else begin
          act[k] = 1'b0; vld[k] = 1'b0; syn[k] = 1'b0; din[k] = '0;
        end
      end
      if (c == rst_at) begin
        rst_n = 1'b0; #1;
        snap = {out_data, out_valid, out_mask, out_sop, out_eop, err_align, err_ovf};
        break;
      end
    end
    @(posedge clk); #1;
    act = '0; vld = '0; syn = '0;
    if (!rst_n) begin repeat (2) @(posedge clk); #1 rst_n = 1'b1; end
    repeat (15) @(posedge clk);
    #1;
  endtask

  // Reference: word i carries every enabled lane that sent an i-th word; lanes that ended are zero.
  task automatic build_exp();
    int s = 0, nmax = 0, nmin = 1000;
    rec_t r;
    exp_q.delete();
    for (int k = 0; k <= int'(lc); k++) begin
      if (sk[k] > s) s = sk[k];
      if (nk[k] > nmax) nmax = nk[k];
      if (nk[k] < nmin) nmin = nk[k];
    end
    for (int i = 0; i < nmax; i++) begin
      r.d = '0; r.m = '0;
      for (int k = 0; k <= int'(lc); k++)
        if (i < nk[k]) begin r.d[k*16 +: 16] = wd[k][i]; r.m[k] = 1'b1; end
      r.cyc = (i < nmin) ? base + s + 2 + i : -1;
      r.sop = (i == 0);
      r.eop = (i == nmax - 1);
      exp_q.push_back(r);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if ({out_data, out_valid, out_mask, out_sop, out_eop, err_align, err_ovf} !== '0) begin
      n_fail++; $display("FAIL reset_hold outputs got %h want 0", {out_data, out_valid, out_mask});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if ({out_data, out_valid, out_mask, out_sop, out_eop, err_align, err_ovf} !== '0) begin
      n_fail++; $display("FAIL reset_idle outputs got %h want 0", {out_data, out_valid, out_mask});
    end
  endtask

  task automatic test_zero_skew();
    set_burst(3, 0, 8);
    for (int k = 0; k < 4; k++) for (int i = 0; i < 8; i++) wd[k][i] = lane_word_t'((k << 8) | i);
    drive(1'b0, -1);
    build_exp();
    n_tests++;
    if (obs_q.size() != exp_q.size() || n_align != 0 || n_ovf != 0) begin
      n_fail++; $display("FAIL zero_skew count got %0d al=%0d ovf=%0d want %0d 0 0", obs_q.size(), n_align, n_ovf, exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].m !== exp_q[i].m || obs_q[i].sop !== exp_q[i].sop ||
          obs_q[i].eop !== exp_q[i].eop || (exp_q[i].cyc >= 0 && obs_q[i].cyc != exp_q[i].cyc)) begin
        n_fail++; $display("FAIL zero_skew w%0d got c=%0d d=%h m=%h s%b e%b want c=%0d d=%h m=%h s%b e%b", i, obs_q[i].cyc, obs_q[i].d, obs_q[i].m, obs_q[i].sop, obs_q[i].eop, exp_q[i].cyc, exp_q[i].d, exp_q[i].m, exp_q[i].sop, exp_q[i].eop);
      end
    end
  endtask

  task automatic test_skew_within();
    set_burst(3, 0, 6);
    sk[0] = 0; sk[1] = 1; sk[2] = 2; sk[3] = 2;
    drive(1'b0, -1);
    build_exp();
    n_tests++;
    if (obs_q.size() != exp_q.size() || n_align != 0 || n_ovf != 0) begin
      n_fail++; $display("FAIL skew_within count got %0d al=%0d ovf=%0d want %0d 0 0", obs_q.size(), n_align, n_ovf, exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].m !== exp_q[i].m || obs_q[i].sop !== exp_q[i].sop ||
          obs_q[i].eop !== exp_q[i].eop || (exp_q[i].cyc >= 0 && obs_q[i].cyc != exp_q[i].cyc)) begin
        n_fail++; $display("FAIL skew_within w%0d got c=%0d d=%h m=%h want c=%0d d=%h m=%h", i, obs_q[i].cyc, obs_q[i].d, obs_q[i].m, exp_q[i].cyc, exp_q[i].d, exp_q[i].m);
      end
    end
  endtask

  task automatic test_skew_exceeded();
    set_burst(3, 0, 6);
    sk[3] = 4;
    drive(1'b0, -1);
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL skew_exc out_valid count got %0d want 0", obs_q.size()); end
    n_tests++;
    if (n_align != 1 || align_cyc != base + 3) begin
      n_fail++; $display("FAIL skew_exc err_align got n=%0d cyc=%0d want n=1 cyc=%0d", n_align, align_cyc, base + 3);
    end
    n_tests++;
    if (n_ovf != 0) begin n_fail++; $display("FAIL skew_exc err_ovf got %0d want 0", n_ovf); end
    set_burst(3, 0, 5);
    drive(1'b0, -1);
    build_exp();
    n_tests++;
    if (obs_q.size() != exp_q.size() || n_align != 0) begin
      n_fail++; $display("FAIL skew_exc recover count got %0d al=%0d want %0d 0", obs_q.size(), n_align, exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].sop !== exp_q[i].sop || obs_q[i].eop !== exp_q[i].eop ||
          obs_q[i].cyc != exp_q[i].cyc) begin
        n_fail++; $display("FAIL skew_exc recover w%0d got c=%0d d=%h want c=%0d d=%h", i, obs_q[i].cyc, obs_q[i].d, exp_q[i].cyc, exp_q[i].d);
      end
    end
  endtask

  task automatic test_uneven_end();
    set_burst(3, 0, 5);
    nk[2] = 4; nk[3] = 4;
    drive(1'b0, -1);
    build_exp();
    n_tests++;
    if (obs_q.size() != 5 || n_ovf != 0) begin
      n_fail++; $display("FAIL uneven count got %0d ovf=%0d want 5 0", obs_q.size(), n_ovf);
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].m !== exp_q[i].m || obs_q[i].sop !== exp_q[i].sop ||
          obs_q[i].eop !== exp_q[i].eop || (exp_q[i].cyc >= 0 && obs_q[i].cyc != exp_q[i].cyc)) begin
        n_fail++; $display("FAIL uneven w%0d got d=%h m=%h e%b want d=%h m=%h e%b", i, obs_q[i].d, obs_q[i].m, obs_q[i].eop, exp_q[i].d, exp_q[i].m, exp_q[i].eop);
      end
    end
  endtask

  task automatic test_lane_cnt1();
    set_burst(1, 2, 7);
    drive(1'b1, -1);
    build_exp();
    n_tests++;
    if (obs_q.size() != exp_q.size() || n_align != 0 || n_ovf != 0) begin
      n_fail++; $display("FAIL lane_cnt1 count got %0d al=%0d ovf=%0d want %0d 0 0", obs_q.size(), n_align, n_ovf, exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].m !== exp_q[i].m || obs_q[i].eop !== exp_q[i].eop ||
          obs_q[i].cyc != exp_q[i].cyc) begin
        n_fail++; $display("FAIL lane_cnt1 w%0d got d=%h m=%h want d=%h m=%h", i, obs_q[i].d, obs_q[i].m, exp_q[i].d, exp_q[i].m);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      set_burst($urandom_range(0, 3), 2, $urandom_range(1, 8));
      drive(1'b0, -1);
      build_exp();
      n_tests++;
      if (obs_q.size() != exp_q.size() || n_align != 0 || n_ovf != 0) begin
        n_fail++; $display("FAIL random%0d count got %0d al=%0d ovf=%0d want %0d 0 0", it, obs_q.size(), n_align, n_ovf, exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_tests++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].m !== exp_q[i].m || obs_q[i].sop !== exp_q[i].sop ||
            obs_q[i].eop !== exp_q[i].eop || (exp_q[i].cyc >= 0 && obs_q[i].cyc != exp_q[i].cyc)) begin
          n_fail++; $display("FAIL random%0d w%0d got c=%0d d=%h m=%h s%b e%b want c=%0d d=%h m=%h s%b e%b", it, i, obs_q[i].cyc, obs_q[i].d, obs_q[i].m, obs_q[i].sop, obs_q[i].eop, exp_q[i].cyc, exp_q[i].d, exp_q[i].m, exp_q[i].sop, exp_q[i].eop);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    set_burst(3, 0, 8);
    drive(1'b0, 3);
    n_tests++;
    if (snap !== '0) begin n_fail++; $display("FAIL rst_mid outputs got %h want 0", snap); end
    set_burst(3, 1, 6);
    drive(1'b0, -1);
    build_exp();
    n_tests++;
    if (obs_q.size() != exp_q.size() || n_align != 0 || n_ovf != 0) begin
      n_fail++; $display("FAIL rst_mid after count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].sop !== exp_q[i].sop || obs_q[i].eop !== exp_q[i].eop ||
          obs_q[i].cyc != exp_q[i].cyc) begin
        n_fail++; $display("FAIL rst_mid after w%0d got c=%0d d=%h s%b want c=%0d d=%h s%b", i, obs_q[i].cyc, obs_q[i].d, obs_q[i].sop, exp_q[i].cyc, exp_q[i].d, exp_q[i].sop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_skew();
    test_skew_within();
    test_skew_exceeded();
    test_uneven_end();
    test_lane_cnt1();
    test_random();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dphy_rx_4lane_aligner.md
Name: dphy_rx_4lane_aligner

Overview:
- Consumes the per-lane HS PPI outputs of the hard 4-lane MIPI D-PHY receiver. This is the RX counterpart of the TX PPI master.
- Deskews lanes that report SYNC on different byte-clock cycles.
- Emits one lane-aligned 64-bit word per cycle, with packet start/end markers and a per-lane valid mask, to the CSI-2/DSI packet layer.
- Detects skew beyond the buffer depth and buffer overflow.

Parameters:
- DATA_W, 16, per-lane HS word width (PPI 16-bit mode).
- SKEW_DEPTH, 4, per-lane deskew FIFO depth in words; power of two, range 2..8.

Ports:
- SLOWCLK  input  1  HS byte clock from the PHY PLL; all logic in this domain.
- RESET_N  input  1  asynchronous active-low reset.
- lane_cnt  input  2  active lanes minus 1 (0=1 lane .. 3=4 lanes); lanes 0..lane_cnt are used. Sampled only in IDLE.
- RX_ACTIVE_HS_LAN0..3  input  1 each  lane in HS receive.
- RX_SYNC_HS_LAN0..3  input  1 each  one-cycle pulse marking the first payload word.
- RX_VALID_HS_LAN0..3  input  1 each  RX_DATA_HS_LANx holds a valid word.
- RX_DATA_HS_LAN0..3  input  DATA_W each  lane word.
- out_data  output  4*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  1  out_data valid.
- out_mask  output  4  per-lane word validity.
- out_sop  output  1  first word of burst.
- out_eop  output  1  last word of burst.
- err_align  output  1  one-cycle pulse: skew exceeded.
- err_ovf  output  1  one-cycle pulse: FIFO overflow.

Behaviour:
- Reset: all outputs 0; all FIFOs empty; FSM in IDLE. Reset asserted mid-burst clears everything immediately (async). No output resumes until a fresh SYNC is seen from IDLE.
- Enabled lanes: en[k] = (k <= lane_cnt), latched on leaving IDLE. Disabled lanes are never written; their out_data slice is 0 and their out_mask bit is 0.
- Lane write: a lane becomes "armed" on RX_SYNC_HS_LANx & RX_VALID_HS_LANx. It writes that word and every later RX_VALID word while RX_ACTIVE_HS_LANx is high. Unarmed lanes write nothing.
- FSM states: IDLE, WAIT_SYNC, STREAM, DRAIN, ERR.
- IDLE -> WAIT_SYNC: first SYNC on any enabled lane. Skew counter starts at 0.
- WAIT_SYNC:
  - Skew counter increments each cycle.
  - -> STREAM when all enabled lanes are armed.
  - -> ERR with err_align pulse if the counter reaches SKEW_DEPTH-1 with any enabled lane still unarmed. Lanes that sync in the same cycle as the limit count as armed.
- STREAM:
  - Pop all enabled FIFOs in the same cycle when all are non-empty.
  - -> DRAIN when every enabled lane has RX_ACTIVE low.
- DRAIN:
  - Pop every cycle while any enabled FIFO is non-empty. Empty lanes give zero data and mask 0.
  - The final pop carries out_eop. Then -> IDLE and arm flags clear.
- ERR: flush FIFOs; no output. -> IDLE when all enabled RX_ACTIVE are low.
- Overflow: a write to a full FIFO gives an err_ovf pulse, -> ERR, and the word is dropped.
- Output register:
  - out_* are registered. A word written at cycle t is poppable at t+1 and appears on out_data at t+2. Minimum latency is 2 cycles after the last lane's SYNC word.
  - out_valid is a one-cycle qualifier per word. There is no backpressure: the downstream must accept every cycle.
- out_sop: high on the first popped word of a burst.
- out_eop: high on the last popped word. sop and eop may coincide for a 1-word burst.
- Simultaneous events: if SYNC arrives on one lane while another lane's ACTIVE drops in WAIT_SYNC, the arm check is evaluated first. Pointer arithmetic is modulo SKEW_DEPTH, using an extra wrap bit for full/empty.

Decomposition:
- Package dphy_rx_pkg holds:
  - rx_state_e enum (IDLE, WAIT_SYNC, STREAM, DRAIN, ERR);
  - NUM_LANES=4 constant;
  - lane_word_t typedef (logic [DATA_W-1:0]).
- One sub-module, dphy_rx_lane_fifo: a single-lane synchronous FIFO with push, pop, flush, full, empty and overflow flags. It is instantiated 4 times.

Test Plan:
- Zero skew: lane_cnt=3; all lanes SYNC at cycle 10 with 8 words, lane k word i = 16'h{k}0{i}. Required: out_valid at cycles 12..19; out_data = {16'h30i,16'h20i,16'h10i,16'h00i}; mask 4'hF; sop at 12, eop at 19.
- Skew within depth: lane0 SYNC at 10, lane1 at 11, lane2/3 at 12. Required: first out_valid at 14, all lanes holding word 0; no errors.
- Skew exceeded: SKEW_DEPTH=4; lane3 SYNC 4 cycles after lane0. Required: err_align pulse at lane0+3; no out_valid; returns to IDLE after ACTIVE drops; the next aligned burst is good.
- Uneven end: lanes 0-1 send 5 words, lanes 2-3 send 4. Required: 5 outputs; the 5th has mask 4'b0011, upper 32 bits 0, and eop.
- lane_cnt=1: lanes 2/3 toggle SYNC, VALID and ACTIVE randomly. Required: ignored; mask 4'b0011 on all words; data[63:32]=0.
- Reset mid-burst: RESET_N low at word 3 of an 8-word burst. Required: all outputs 0 the same cycle; after release, a new burst with latency 2 and sop correct.
